// File: rtl/ls_mem_ctrl.sv
// ----------------------------------------------------------------------------
// ls_mem_ctrl
//
// Load/store sequencer between the load-store station's register-read stage
// and the data-memory port. It accepts one op at a time, issues a single
// memory request, waits out a variable memory latency, and broadcasts the
// result on the CDB once a slot is granted. Misaligned addresses bypass
// memory and complete immediately with an exception. A branch recovery that
// names the in-flight op cancels its broadcast.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   in_*                 issued op (valid, rob, dest preg, base, store data,
//                        16-bit offset, load/store select)
//   recover/rob_num_rec  branch recovery and the ROB number being flushed
//   mem_*                memory request / write enable / address / wdata,
//                        ack and load data back
//   cdb_req/cdb_grant    CDB slot request and grant
//   cmpl_*               completion fields broadcast while cdb_req is high
//   lsc_busy             high whenever an op is in flight (stalls station)
// ----------------------------------------------------------------------------
module ls_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ROB_W-1:0]  in_rob,
    input  logic [PREG_W-1:0] in_p_rd,
    input  logic [DATA_W-1:0] in_base,
    input  logic [DATA_W-1:0] in_sdata,
    input  logic [15:0]       in_immed,
    input  logic              in_ren,
    input  logic              in_wen,
    input  logic              recover,
    input  logic [ROB_W-1:0]  rob_num_rec,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic [ROB_W-1:0]  cmpl_rob,
    output logic [PREG_W-1:0] cmpl_p_rd,
    output logic              cmpl_regdest,
    output logic [DATA_W-1:0] cmpl_data,
    output logic              cmpl_exc,
    output logic              lsc_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CMPL = 2'd2
    } state_t;

    state_t              r_state;
    logic [ROB_W-1:0]    r_rob;
    logic [PREG_W-1:0]   r_p_rd;
    logic                r_ren;
    logic                r_squash;

    logic                r_mem_req;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cdb_req;
    logic [ROB_W-1:0]    r_cmpl_rob;
    logic [PREG_W-1:0]   r_cmpl_p_rd;
    logic                r_cmpl_regdest;
    logic [DATA_W-1:0]   r_cmpl_data;
    logic                r_cmpl_exc;
    logic                r_busy;

    // Effective address wraps modulo 2^DATA_W; offset is sign-extended.
    logic [DATA_W-1:0]   w_addr;
    logic                w_accept;
    logic                w_rec_hit;

    assign w_addr    = in_base + {{(DATA_W-16){in_immed[15]}}, in_immed};
    assign w_accept  = in_valid && (in_ren ^ in_wen) &&
                       !(recover && (rob_num_rec == in_rob));
    assign w_rec_hit = recover && (rob_num_rec == r_rob);

    // NOTE: every register, including the holding latches, is reset so that
    // all outputs read 0 straight out of reset and after a mid-flight abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_rob          <= '0;
            r_p_rd         <= '0;
            r_ren          <= 1'b0;
            r_squash       <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_cdb_req      <= 1'b0;
            r_cmpl_rob     <= '0;
            r_cmpl_p_rd    <= '0;
            r_cmpl_regdest <= 1'b0;
            r_cmpl_data    <= '0;
            r_cmpl_exc     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the state as it was at the start of the cycle.
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rob  <= in_rob;
                        r_p_rd <= in_p_rd;
                        r_ren  <= in_ren;
                        r_busy <= 1'b1;
                        if (w_addr[1:0] != 2'b00) begin
                            // Misaligned: never touches memory.
                            r_state        <= CMPL;
                            r_cdb_req      <= 1'b1;
                            r_cmpl_rob     <= in_rob;
                            r_cmpl_p_rd    <= in_ren ? in_p_rd : '0;
                            r_cmpl_regdest <= 1'b0;
                            r_cmpl_data    <= '0;
                            r_cmpl_exc     <= 1'b1;
                        end else begin
                            r_state     <= REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= in_wen;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= in_wen ? in_sdata : '0;
                        end
                    end
                end

                REQ: begin
                    // The request is never retracted; a squash only
                    // suppresses the broadcast once memory has answered.
                    if (w_rec_hit) begin
                        r_squash <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        if (r_squash || w_rec_hit) begin
                            r_state  <= IDLE;
                            r_busy   <= 1'b0;
                            r_squash <= 1'b0;
                        end else begin
                            r_state        <= CMPL;
                            r_cdb_req      <= 1'b1;
                            r_cmpl_rob     <= r_rob;
                            r_cmpl_p_rd    <= r_ren ? r_p_rd : '0;
                            r_cmpl_regdest <= r_ren;
                            r_cmpl_data    <= r_ren ? mem_rdata : '0;
                            r_cmpl_exc     <= 1'b0;
                        end
                    end
                end

                CMPL: begin
                    // A matching recover wins over a same-cycle grant.
                    if (w_rec_hit || cdb_grant) begin
                        r_state        <= IDLE;
                        r_busy         <= 1'b0;
                        r_squash       <= 1'b0;
                        r_cdb_req      <= 1'b0;
                        r_cmpl_rob     <= '0;
                        r_cmpl_p_rd    <= '0;
                        r_cmpl_regdest <= 1'b0;
                        r_cmpl_data    <= '0;
                        r_cmpl_exc     <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign cdb_req      = r_cdb_req;
    assign cmpl_rob     = r_cmpl_rob;
    assign cmpl_p_rd    = r_cmpl_p_rd;
    assign cmpl_regdest = r_cmpl_regdest;
    assign cmpl_data    = r_cmpl_data;
    assign cmpl_exc     = r_cmpl_exc;
    assign lsc_busy     = r_busy;

endmodule

// File: tb/tb_ls_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ls_mem_ctrl
//
// Directed bench for ls_mem_ctrl. Inputs change 1 ns after the rising edge
// and outputs are sampled at that same point, well away from the edge.
// ----------------------------------------------------------------------------
module tb_ls_mem_ctrl;

    localparam int DATA_W = 32;
    localparam int ROB_W  = 4;
    localparam int PREG_W = 6;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [ROB_W-1:0]  in_rob;
    logic [PREG_W-1:0] in_p_rd;
    logic [DATA_W-1:0] in_base;
    logic [DATA_W-1:0] in_sdata;
    logic [15:0]       in_immed;
    logic              in_ren;
    logic              in_wen;
    logic              recover;
    logic [ROB_W-1:0]  rob_num_rec;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              cdb_req;
    logic              cdb_grant;
    logic [ROB_W-1:0]  cmpl_rob;
    logic [PREG_W-1:0] cmpl_p_rd;
    logic              cmpl_regdest;
    logic [DATA_W-1:0] cmpl_data;
    logic              cmpl_exc;
    logic              lsc_busy;

    int checks   = 0;
    int failures = 0;

    ls_mem_ctrl #(.DATA_W(DATA_W), .ROB_W(ROB_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_rob(in_rob), .in_p_rd(in_p_rd),
        .in_base(in_base), .in_sdata(in_sdata), .in_immed(in_immed),
        .in_ren(in_ren), .in_wen(in_wen),
        .recover(recover), .rob_num_rec(rob_num_rec),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cdb_req(cdb_req), .cdb_grant(cdb_grant),
        .cmpl_rob(cmpl_rob), .cmpl_p_rd(cmpl_p_rd),
        .cmpl_regdest(cmpl_regdest), .cmpl_data(cmpl_data),
        .cmpl_exc(cmpl_exc), .lsc_busy(lsc_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [ROB_W-1:0] rob, input logic [PREG_W-1:0] prd,
                            input logic [DATA_W-1:0] base, input logic [15:0] imm,
                            input logic [DATA_W-1:0] sd, input logic ren, input logic wen);
        in_valid = 1'b1; in_rob = rob; in_p_rd = prd; in_base = base;
        in_immed = imm; in_sdata = sd; in_ren = ren; in_wen = wen;
    endtask

    task automatic clear_op();
        in_valid = 1'b0; in_rob = '0; in_p_rd = '0; in_base = '0;
        in_immed = '0; in_sdata = '0; in_ren = 1'b0; in_wen = 1'b0;
    endtask

    task automatic test_reset();
        clear_op();
        recover = 1'b0; rob_num_rec = '0; mem_ack = 1'b0; mem_rdata = '0; cdb_grant = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        checks++; if ({mem_req, mem_we, cdb_req, cmpl_regdest, cmpl_exc, lsc_busy} !== 6'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=000000", {mem_req, mem_we, cdb_req, cmpl_regdest, cmpl_exc, lsc_busy}); end
        checks++; if ({mem_addr, mem_wdata, cmpl_data} !== 96'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", mem_addr, mem_wdata, cmpl_data); end
        checks++; if ({cmpl_rob, cmpl_p_rd} !== 10'h0) begin failures++; $display("FAIL reset_tags got=%h/%h exp=0", cmpl_rob, cmpl_p_rd); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load();
        drive_op(4'd3, 6'd9, 32'h100, 16'hFFFC, 32'hAAAA_AAAA, 1'b1, 1'b0);
        tick();
        clear_op();
        checks++; if ({mem_req, mem_we, lsc_busy} !== 3'b101) begin failures++; $display("FAIL load_req got=%b exp=101", {mem_req, mem_we, lsc_busy}); end
        checks++; if (mem_addr !== 32'hFC) begin failures++; $display("FAIL load_addr got=%h exp=000000fc", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL load_wdata got=%h exp=0", mem_wdata); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({mem_req, cdb_req, mem_addr} !== {2'b10, 32'hFC}) begin failures++; $display("FAIL load_hold%0d got=%b%b %h", i, mem_req, cdb_req, mem_addr); end
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        checks++; if ({mem_req, cdb_req, cmpl_regdest, cmpl_exc} !== 4'b0110) begin failures++; $display("FAIL load_cmpl_ctl got=%b exp=0110", {mem_req, cdb_req, cmpl_regdest, cmpl_exc}); end
        checks++; if ({cmpl_rob, cmpl_p_rd} !== {4'd3, 6'd9}) begin failures++; $display("FAIL load_cmpl_tags got=%0d/%0d exp=3/9", cmpl_rob, cmpl_p_rd); end
        checks++; if (cmpl_data !== 32'hDEADBEEF) begin failures++; $display("FAIL load_cmpl_data got=%h exp=deadbeef", cmpl_data); end
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        checks++; if ({cdb_req, lsc_busy} !== 2'b00) begin failures++; $display("FAIL load_idle got=%b exp=00", {cdb_req, lsc_busy}); end
    endtask

    task automatic test_store();
        drive_op(4'd1, 6'd12, 32'h200, 16'h0004, 32'h55, 1'b0, 1'b1);
        tick();
        clear_op();
        checks++; if ({mem_req, mem_we} !== 2'b11) begin failures++; $display("FAIL store_req got=%b exp=11", {mem_req, mem_we}); end
        checks++; if ({mem_addr, mem_wdata} !== {32'h204, 32'h55}) begin failures++; $display("FAIL store_fields got=%h/%h exp=00000204/00000055", mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({cdb_req, cmpl_regdest, cmpl_exc, mem_req} !== 4'b1000) begin failures++; $display("FAIL store_wait%0d got=%b exp=1000", i, {cdb_req, cmpl_regdest, cmpl_exc, mem_req}); end
            checks++; if ({cmpl_rob, cmpl_p_rd, cmpl_data} !== {4'd1, 6'd0, 32'd0}) begin failures++; $display("FAIL store_fields%0d got=%0d/%0d/%h exp=1/0/0", i, cmpl_rob, cmpl_p_rd, cmpl_data); end
            tick();
        end
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        checks++; if ({cdb_req, lsc_busy} !== 2'b00) begin failures++; $display("FAIL store_idle got=%b exp=00", {cdb_req, lsc_busy}); end
    endtask

    task automatic test_misaligned();
        drive_op(4'd2, 6'd4, 32'h102, 16'h0000, 32'h0, 1'b1, 1'b0);
        tick();
        clear_op();
        checks++; if ({mem_req, cdb_req, cmpl_exc, cmpl_regdest, lsc_busy} !== 5'b01101) begin failures++; $display("FAIL misal_ctl got=%b exp=01101", {mem_req, cdb_req, cmpl_exc, cmpl_regdest, lsc_busy}); end
        checks++; if ({cmpl_rob, cmpl_data} !== {4'd2, 32'd0}) begin failures++; $display("FAIL misal_fields got=%0d/%h exp=2/0", cmpl_rob, cmpl_data); end
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        checks++; if ({cdb_req, cmpl_exc, lsc_busy, mem_req} !== 4'b0000) begin failures++; $display("FAIL misal_idle got=%b exp=0000", {cdb_req, cmpl_exc, lsc_busy, mem_req}); end
    endtask

    task automatic test_squash_req();
        drive_op(4'd5, 6'd7, 32'h40, 16'h0000, 32'h0, 1'b1, 1'b0);
        tick();
        clear_op();
        recover = 1'b1; rob_num_rec = 4'd5;
        tick();
        recover = 1'b0; rob_num_rec = '0;
        checks++; if ({mem_req, lsc_busy, mem_addr} !== {2'b11, 32'h40}) begin failures++; $display("FAIL sqreq_hold got=%b%b %h exp=11 00000040", mem_req, lsc_busy, mem_addr); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        checks++; if ({mem_req, cdb_req, lsc_busy} !== 3'b000) begin failures++; $display("FAIL sqreq_done got=%b exp=000", {mem_req, cdb_req, lsc_busy}); end
        tick();
        checks++; if (cdb_req !== 1'b0) begin failures++; $display("FAIL sqreq_nocdb got=%b exp=0", cdb_req); end
    endtask

    task automatic test_squash_cmpl();
        // Matching recover with a simultaneous grant: the grant is wasted.
        drive_op(4'd5, 6'd3, 32'h80, 16'h0000, 32'h0, 1'b1, 1'b0);
        tick();
        clear_op();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        checks++; if (cdb_req !== 1'b1) begin failures++; $display("FAIL sqcmpl_req got=%b exp=1", cdb_req); end
        recover = 1'b1; rob_num_rec = 4'd5; cdb_grant = 1'b1;
        tick();
        recover = 1'b0; rob_num_rec = '0; cdb_grant = 1'b0;
        checks++; if ({cdb_req, lsc_busy} !== 2'b00) begin failures++; $display("FAIL sqcmpl_drop got=%b exp=00", {cdb_req, lsc_busy}); end

        // Non-matching recover leaves the completion intact.
        drive_op(4'd5, 6'd3, 32'h84, 16'h0000, 32'h0, 1'b1, 1'b0);
        tick();
        clear_op();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0002;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        recover = 1'b1; rob_num_rec = 4'd7;
        tick();
        recover = 1'b0; rob_num_rec = '0;
        checks++; if ({cdb_req, cmpl_regdest, cmpl_data} !== {2'b11, 32'hCAFE_0002}) begin failures++; $display("FAIL sqcmpl_keep got=%b%b %h exp=11 cafe0002", cdb_req, cmpl_regdest, cmpl_data); end
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        checks++; if ({cdb_req, lsc_busy} !== 2'b00) begin failures++; $display("FAIL sqcmpl_idle got=%b exp=00", {cdb_req, lsc_busy}); end
    endtask

    task automatic test_back_to_back();
        // Both ren and wen set: not a legal op, must be ignored.
        drive_op(4'd6, 6'd1, 32'h300, 16'h0000, 32'h0, 1'b1, 1'b1);
        tick();
        checks++; if ({mem_req, cdb_req, lsc_busy} !== 3'b000) begin failures++; $display("FAIL illegal_op got=%b exp=000", {mem_req, cdb_req, lsc_busy}); end

        // Address wrap-around.
        drive_op(4'd8, 6'd2, 32'hFFFF_FFFC, 16'h0008, 32'h99, 1'b0, 1'b1);
        tick();
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h4}) begin failures++; $display("FAIL wrap_addr got=%b %h exp=1 00000004", mem_req, mem_addr); end
        // A new op while busy is ignored.
        drive_op(4'd9, 6'd3, 32'h500, 16'h0000, 32'h77, 1'b0, 1'b1);
        tick();
        clear_op();
        checks++; if ({mem_addr, mem_wdata} !== {32'h4, 32'h99}) begin failures++; $display("FAIL busy_ignore got=%h/%h exp=00000004/00000099", mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if ({cdb_req, cmpl_rob} !== {1'b1, 4'd8}) begin failures++; $display("FAIL wrap_cmpl got=%b/%0d exp=1/8", cdb_req, cmpl_rob); end
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;

        // Asynchronous reset in REQ.
        drive_op(4'd4, 6'd5, 32'h600, 16'h0000, 32'h0, 1'b1, 1'b0);
        tick();
        clear_op();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_pre got=%b exp=1", mem_req); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({mem_req, lsc_busy, cdb_req} !== 3'b000) begin failures++; $display("FAIL async_rst got=%b exp=000", {mem_req, lsc_busy, cdb_req}); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if ({mem_req, lsc_busy} !== 2'b00) begin failures++; $display("FAIL post_rst got=%b exp=00", {mem_req, lsc_busy}); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_squash_req();
        test_squash_cmpl();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
